// File: rtl/instr_loader.sv
// Serial program loader: length byte, 4*N big-endian data bytes, XOR checksum byte -> instruction-memory writes.
// Releases cpu_reset only once the whole program has arrived with a matching checksum.
module instr_loader #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR} state_t;

    state_t      state, state_nxt;
    logic [7:0]  n_words;
    logic [7:0]  word_idx;
    logic [7:0]  csum;
    logic [1:0]  byte_cnt;
    logic [23:0] word_acc;
    logic        accept;
    logic        len_bad;

    assign accept  = byte_valid && byte_ready;
    assign len_bad = (byte_data == 8'd0) || (32'(byte_data) > DEPTH);

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        cpu_reset  = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LEN;
            end
            LEN: begin
                byte_ready = 1'b1;
                if (accept) state_nxt = len_bad ? ERR : DATA;
            end
            DATA: begin
                byte_ready = 1'b1;
                if (accept && byte_cnt == 2'd3) state_nxt = WRITE;
            end
            WRITE: begin
                wr_en     = 1'b1;
                state_nxt = (word_idx + 8'd1 == n_words) ? CSUM : DATA;
            end
            CSUM: begin
                byte_ready = 1'b1;
                if (accept) state_nxt = (byte_data == csum) ? DONE : ERR;
            end
            DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
                if (start) state_nxt = LEN;
            end
            ERR: begin
                error = 1'b1;
                if (start) state_nxt = LEN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            n_words  <= 8'd0;
            word_idx <= 8'd0;
            csum     <= 8'd0;
            byte_cnt <= 2'd0;
            word_acc <= 24'd0;
            wr_addr  <= 32'd0;
            wr_data  <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        n_words  <= 8'd0;
                        word_idx <= 8'd0;
                        csum     <= 8'd0;
                        byte_cnt <= 2'd0;
                    end
                end
                LEN: begin
                    if (accept && !len_bad) n_words <= byte_data;
                end
                DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        csum     <= csum ^ byte_data;
                        word_acc <= {word_acc[15:0], byte_data};
                        // Write port registers load only on the completing byte so they hold between strobes.
                        if (byte_cnt == 2'd3) begin
                            wr_data <= {word_acc, byte_data};
                            wr_addr <= {22'd0, word_idx, 2'b00};
                        end
                    end
                end
                WRITE: word_idx <= word_idx + 8'd1;
                default: ;
            endcase
        end
    end

endmodule
